// File: rtl/kbd_serial_link_if.sv
// kbd_serial_link_if
//   Bundles the VIA shift-register lines and the byte-level handshakes
//   between the serial link engine and the keyboard / ADB models.
//   master : the link engine (drives the bit clock, CB2 input data and the
//            Mac-to-peripheral byte strobes).
//   slave  : the surrounding VIA and peripheral models.
//   Signals:
//     cb2_o, cb2_t      VIA CB2 output value and its drive enable
//     kbdclk            bit clock toward VIA CB1
//     kbddata_o         serial data toward the VIA CB2 input
//     adb_listen        ADB transceiver asks for a VIA-to-ADB byte
//     kbd_in_data/_strobe, adb_dout/_strobe     bytes destined for the Mac
//     kbd_out_data/_strobe, adb_din/_strobe     bytes coming from the Mac
interface kbd_serial_link_if;
    logic       cb2_o;
    logic       cb2_t;
    logic       kbdclk;
    logic       kbddata_o;
    logic       adb_listen;
    logic [7:0] kbd_in_data;
    logic       kbd_in_strobe;
    logic [7:0] adb_dout;
    logic       adb_dout_strobe;
    logic [7:0] kbd_out_data;
    logic       kbd_out_strobe;
    logic [7:0] adb_din;
    logic       adb_din_strobe;

    modport master (
        input  cb2_o, cb2_t, adb_listen,
        input  kbd_in_data, kbd_in_strobe, adb_dout, adb_dout_strobe,
        output kbdclk, kbddata_o,
        output kbd_out_data, kbd_out_strobe, adb_din, adb_din_strobe
    );

    modport slave (
        output cb2_o, cb2_t, adb_listen,
        output kbd_in_data, kbd_in_strobe, adb_dout, adb_dout_strobe,
        input  kbdclk, kbddata_o,
        input  kbd_out_data, kbd_out_strobe, adb_din, adb_din_strobe
    );
endinterface

// File: rtl/kbd_serial_link.sv
// kbd_serial_link
//   Serial link engine between the VIA shift register (CB1 clock, CB2 data)
//   and either the Mac Plus keyboard or the Mac SE ADB transceiver. It also
//   stretches the system reset into the CPU reset. The engine generates the
//   bit clock, shifts bytes in both directions (MSB first) and exchanges
//   whole bytes with the peripheral models through one-enable strobes.
//   Ports:
//     clk           16 MHz system clock
//     _systemReset  asynchronous active-low reset
//     clk8_en_p     8 MHz enable; every register advances only on it
//     machineType   0 = Mac Plus keyboard, 1 = Mac SE ADB
//     _cpuReset     active-low CPU reset (high once the counter hits zero)
//     via_busy      transmitting or receiving
//     link          VIA / peripheral bundle (master side)
module kbd_serial_link #(
    parameter logic [19:0] RESET_CYCLES = 20'hFFFFF
) (
    input  logic clk,
    input  logic _systemReset,
    input  logic clk8_en_p,
    input  logic machineType,
    output logic _cpuReset,
    output logic via_busy,
    kbd_serial_link_if.master link
);

    // Half bit period minus one, in enables.
    localparam logic [10:0] HALF_PLUS = 11'd1300;
    localparam logic [10:0] HALF_SE   = 11'd80;

    logic [19:0] reset_cnt_r;

    logic        transmitting_r,   transmitting_nxt;
    logic        wait_rx_r,        wait_rx_nxt;
    logic        receiving_r,      receiving_nxt;
    logic        data_valid_r,     data_valid_nxt;
    logic [2:0]  bitcnt_r,         bitcnt_nxt;
    logic        listen_d_r,       listen_d_nxt;
    logic        kbd_out_strobe_r, kbd_out_strobe_nxt;
    logic        adb_din_strobe_r, adb_din_strobe_nxt;
    logic        kbdclk_r,         kbdclk_nxt;
    logic        kbdclk_d_r,       kbdclk_d_nxt;
    logic        kbddata_o_r,      kbddata_o_nxt;
    logic [10:0] cnt_r,            cnt_nxt;
    logic [7:0]  to_mac_r,         to_mac_nxt;
    logic [7:0]  kbd_out_data_r,   kbd_out_data_nxt;
    logic [7:0]  adb_din_r,        adb_din_nxt;

    logic        srst_s;
    logic        kbddat_i_s;
    logic        clk_active_s;
    logic        rise_s;
    logic        idle_s;
    logic [10:0] half_s;

    // The CPU reset doubles as the synchronous clear of the whole link.
    assign srst_s       = (reset_cnt_r == 20'd0) ? 1'b0 : 1'b1;
    // An undriven CB2 line floats high.
    assign kbddat_i_s   = ~link.cb2_t | link.cb2_o;
    assign clk_active_s = (transmitting_r & ~wait_rx_r) | receiving_r;
    assign rise_s       = ~kbdclk_d_r & kbdclk_r;
    assign idle_s       = ~transmitting_r & ~receiving_r;
    assign half_s       = machineType ? HALF_SE : HALF_PLUS;

    // CPU reset stretch counter: reloads asynchronously, counts enables down to zero.
    always_ff @(posedge clk or negedge _systemReset) begin
        if (!_systemReset) begin
            reset_cnt_r <= RESET_CYCLES;
        end else if (clk8_en_p && (reset_cnt_r != 20'd0)) begin
            reset_cnt_r <= reset_cnt_r - 20'd1;
        end else begin
            reset_cnt_r <= reset_cnt_r;
        end
    end

    // Link state register, advanced on each enable.
    always_ff @(posedge clk or negedge _systemReset) begin
        if (!_systemReset) begin
            transmitting_r   <= 1'b0;
            wait_rx_r        <= 1'b0;
            receiving_r      <= 1'b0;
            data_valid_r     <= 1'b0;
            bitcnt_r         <= 3'd0;
            listen_d_r       <= 1'b0;
            kbd_out_strobe_r <= 1'b0;
            adb_din_strobe_r <= 1'b0;
            kbdclk_r         <= 1'b1;
            kbdclk_d_r       <= 1'b1;
            kbddata_o_r      <= 1'b1;
            cnt_r            <= 11'd0;
            to_mac_r         <= 8'd0;
            kbd_out_data_r   <= 8'd0;
            adb_din_r        <= 8'd0;
        end else if (clk8_en_p) begin
            transmitting_r   <= transmitting_nxt;
            wait_rx_r        <= wait_rx_nxt;
            receiving_r      <= receiving_nxt;
            data_valid_r     <= data_valid_nxt;
            bitcnt_r         <= bitcnt_nxt;
            listen_d_r       <= listen_d_nxt;
            kbd_out_strobe_r <= kbd_out_strobe_nxt;
            adb_din_strobe_r <= adb_din_strobe_nxt;
            kbdclk_r         <= kbdclk_nxt;
            kbdclk_d_r       <= kbdclk_d_nxt;
            kbddata_o_r      <= kbddata_o_nxt;
            cnt_r            <= cnt_nxt;
            to_mac_r         <= to_mac_nxt;
            kbd_out_data_r   <= kbd_out_data_nxt;
            adb_din_r        <= adb_din_nxt;
        end else begin
            transmitting_r   <= transmitting_r;
            wait_rx_r        <= wait_rx_r;
            receiving_r      <= receiving_r;
            data_valid_r     <= data_valid_r;
            bitcnt_r         <= bitcnt_r;
            listen_d_r       <= listen_d_r;
            kbd_out_strobe_r <= kbd_out_strobe_r;
            adb_din_strobe_r <= adb_din_strobe_r;
            kbdclk_r         <= kbdclk_r;
            kbdclk_d_r       <= kbdclk_d_r;
            kbddata_o_r      <= kbddata_o_r;
            cnt_r            <= cnt_r;
            to_mac_r         <= to_mac_r;
            kbd_out_data_r   <= kbd_out_data_r;
            adb_din_r        <= adb_din_r;
        end
    end

    // Next-state logic. Statement order sets priority on coincident events:
    // strobe load, then start, then wait-to-receive, then end-of-byte.
    always_comb begin
        transmitting_nxt   = transmitting_r;
        wait_rx_nxt        = wait_rx_r;
        receiving_nxt      = receiving_r;
        data_valid_nxt     = data_valid_r;
        bitcnt_nxt         = bitcnt_r;
        listen_d_nxt       = listen_d_r;
        kbd_out_strobe_nxt = 1'b0;
        adb_din_strobe_nxt = 1'b0;
        kbdclk_nxt         = kbdclk_r;
        kbdclk_d_nxt       = kbdclk_r;
        kbddata_o_nxt      = kbddata_o_r;
        cnt_nxt            = cnt_r;
        to_mac_nxt         = to_mac_r;
        kbd_out_data_nxt   = kbd_out_data_r;
        adb_din_nxt        = adb_din_r;

        if (srst_s) begin
            transmitting_nxt = 1'b0;
            wait_rx_nxt      = 1'b0;
            receiving_nxt    = 1'b0;
            data_valid_nxt   = 1'b0;
            bitcnt_nxt       = 3'd0;
            listen_d_nxt     = 1'b0;
            kbdclk_nxt       = 1'b1;
            kbddata_o_nxt    = 1'b1;
            cnt_nxt          = 11'd0;
        end else begin
            // Bit clock: a half period is HALF+1 enables, parked high when idle.
            if (clk_active_s) begin
                if (cnt_r == half_s) begin
                    cnt_nxt    = 11'd0;
                    kbdclk_nxt = ~kbdclk_r;
                    if (kbdclk_r) begin
                        // Falling edge: sample the VIA bit, present the next Mac bit.
                        if (transmitting_r) begin
                            kbd_out_data_nxt = {kbd_out_data_r[6:0], kbddat_i_s};
                        end else begin
                            kbd_out_data_nxt = kbd_out_data_r;
                        end
                        if (receiving_r) begin
                            // ~bitcnt == 7 - bitcnt, so bit 7 goes out first.
                            kbddata_o_nxt = to_mac_r[~bitcnt_r];
                        end else begin
                            kbddata_o_nxt = kbddata_o_r;
                        end
                    end else begin
                        kbddata_o_nxt = kbddata_o_r;
                    end
                end else begin
                    cnt_nxt = cnt_r + 11'd1;
                end
            end else begin
                cnt_nxt    = 11'd0;
                kbdclk_nxt = 1'b1;
            end

            if (!machineType) begin
                if (link.kbd_in_strobe) begin
                    to_mac_nxt     = link.kbd_in_data;
                    data_valid_nxt = 1'b1;
                end else begin
                    to_mac_nxt = to_mac_r;
                end
                // The VIA pulling CB2 low starts a Mac-to-keyboard byte.
                if (idle_s && !kbddat_i_s) begin
                    transmitting_nxt = 1'b1;
                    bitcnt_nxt       = 3'd0;
                end else begin
                    bitcnt_nxt = bitcnt_r;
                end
                // Keyboard answer goes out once CB2 is released and a byte is ready.
                if (wait_rx_r && kbddat_i_s && data_valid_r) begin
                    receiving_nxt    = 1'b1;
                    transmitting_nxt = 1'b0;
                    wait_rx_nxt      = 1'b0;
                end else begin
                    wait_rx_nxt = wait_rx_r;
                end
            end else begin
                if (link.adb_dout_strobe) begin
                    to_mac_nxt    = link.adb_dout;
                    receiving_nxt = 1'b1;
                end else begin
                    to_mac_nxt = to_mac_r;
                end
                if (idle_s) begin
                    listen_d_nxt = link.adb_listen;
                    if (link.adb_listen && !listen_d_r) begin
                        transmitting_nxt = 1'b1;
                        bitcnt_nxt       = 3'd0;
                    end else begin
                        bitcnt_nxt = bitcnt_r;
                    end
                end else begin
                    listen_d_nxt = listen_d_r;
                end
            end

            // End of byte on the eighth rising edge.
            if (rise_s) begin
                bitcnt_nxt = bitcnt_r + 3'd1;
                if (bitcnt_r == 3'd7) begin
                    if (transmitting_r) begin
                        if (!machineType) begin
                            kbd_out_strobe_nxt = 1'b1;
                            wait_rx_nxt        = 1'b1;
                        end else begin
                            adb_din_nxt        = kbd_out_data_r;
                            adb_din_strobe_nxt = 1'b1;
                            transmitting_nxt   = 1'b0;
                        end
                    end else begin
                        adb_din_nxt = adb_din_r;
                    end
                    if (receiving_r) begin
                        receiving_nxt  = 1'b0;
                        data_valid_nxt = 1'b0;
                    end else begin
                        data_valid_nxt = data_valid_nxt;
                    end
                end else begin
                    adb_din_nxt = adb_din_r;
                end
            end else begin
                adb_din_nxt = adb_din_r;
            end
        end
    end

    // Outputs: all driven straight from registers.
    always_comb begin
        _cpuReset           = ~srst_s;
        via_busy            = transmitting_r | receiving_r;
        link.kbdclk         = kbdclk_r;
        link.kbddata_o      = kbddata_o_r;
        link.kbd_out_data   = kbd_out_data_r;
        link.kbd_out_strobe = kbd_out_strobe_r;
        link.adb_din        = adb_din_r;
        link.adb_din_strobe = adb_din_strobe_r;
    end

endmodule

// File: tb/tb_kbd_serial_link.sv
// tb_kbd_serial_link
//   Self-checking bench for kbd_serial_link. Expected bytes and bits are
//   queued when stimulus is applied and compared when the DUT produces them.
module tb_kbd_serial_link;

    localparam logic [19:0] RST_CYC = 20'd16;

    logic clk = 1'b0;
    logic _systemReset;
    logic clk8_en_p;
    logic machineType;
    logic _cpuReset;
    logic via_busy;
    logic en_full;
    logic en_phase;

    kbd_serial_link_if link_if ();

    kbd_serial_link #(.RESET_CYCLES(RST_CYC)) dut (
        .clk          (clk),
        ._systemReset (_systemReset),
        .clk8_en_p    (clk8_en_p),
        .machineType  (machineType),
        ._cpuReset    (_cpuReset),
        .via_busy     (via_busy),
        .link         (link_if.master)
    );

    always #5 clk = ~clk;

    // Enable is either every clock or every other clock.
    assign clk8_en_p = en_full | en_phase;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int en_count  = 0;
    int fall_cnt  = 0;
    int kbd_strobe_cnt = 0;
    int adb_strobe_cnt = 0;
    int last_toggle = 0;
    int exp_half = 1301;
    logic half_valid = 1'b0;
    logic rx_mon = 1'b0;
    logic [7:0] byte_q[$];
    logic       bit_q[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        check_cnt++;
        if (obs == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_falls(input int limit, input string tag);
        int start = fall_cnt;
        int n = 0;
        while ((fall_cnt == start) && (n < limit)) begin
            @(negedge clk); #1; n++;
        end
        check_eq(tag, fall_cnt - start, 1);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while (via_busy && (n < limit)) begin
            @(negedge clk); #1; n++;
        end
        check_eq(tag, via_busy, 0);
    endtask

    task automatic wait_cpu_reset(input int limit, input string tag);
        int t0 = en_count;
        int n = 0;
        while (!_cpuReset && (n < limit)) begin
            @(negedge clk); #1; n++;
        end
        check_eq(tag, _cpuReset, 1);
        check_eq({tag, "_len"}, en_count - t0, 16);
    endtask

    task automatic wait_strobe(input bit adb, input int limit, input string tag);
        int s0 = adb ? adb_strobe_cnt : kbd_strobe_cnt;
        int n = 0;
        while (((adb ? adb_strobe_cnt : kbd_strobe_cnt) == s0) && (n < limit)) begin
            @(negedge clk); #1; n++;
        end
        check_eq(tag, (adb ? adb_strobe_cnt : kbd_strobe_cnt) - s0, 1);
    endtask

    task automatic wait_clk_high(input int limit, input string tag);
        int n = 0;
        while (!link_if.kbdclk && (n < limit)) begin
            @(negedge clk); #1; n++;
        end
        check_eq(tag, link_if.kbdclk, 1);
    endtask

    // Enable phase toggles away from the active edge.
    initial begin
        en_phase = 1'b0;
        forever begin
            @(negedge clk);
            en_phase = ~en_phase;
        end
    end

    // Count enables seen by the DUT.
    initial begin
        forever begin
            @(posedge clk);
            if (clk8_en_p) en_count++;
        end
    end

    // Output monitor: half periods, received bits and byte strobes.
    initial begin
        logic kbdclk_prev = 1'b1;
        logic kos_prev = 1'b0;
        logic ads_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (link_if.kbdclk !== kbdclk_prev) begin
                if (half_valid) check_eq("half_period", en_count - last_toggle, exp_half);
                last_toggle = en_count;
                half_valid  = 1'b1;
                if (link_if.kbdclk === 1'b0) begin
                    fall_cnt++;
                    if (rx_mon) begin
                        if (bit_q.size() > 0) check_eq("rx_bit", link_if.kbddata_o, bit_q.pop_front());
                        else check_eq("rx_bit_unexpected", bit_q.size(), 1);
                    end
                end
            end
            kbdclk_prev = link_if.kbdclk;
            if (link_if.kbd_out_strobe && !kos_prev) begin
                kbd_strobe_cnt++;
                if (byte_q.size() > 0) check_eq("kbd_out_data", link_if.kbd_out_data, byte_q.pop_front());
                else check_eq("kbd_out_strobe_unexpected", link_if.kbd_out_strobe, 0);
            end
            kos_prev = link_if.kbd_out_strobe;
            if (link_if.adb_din_strobe && !ads_prev) begin
                adb_strobe_cnt++;
                if (byte_q.size() > 0) check_eq("adb_din", link_if.adb_din, byte_q.pop_front());
                else check_eq("adb_din_strobe_unexpected", link_if.adb_din_strobe, 0);
            end
            ads_prev = link_if.adb_din_strobe;
        end
    end

    initial begin
        logic [7:0] data;
        int f0;
        int s0;

        _systemReset = 1'b0;
        machineType  = 1'b0;
        en_full      = 1'b0;
        link_if.cb2_o = 1'b1;
        link_if.cb2_t = 1'b0;
        link_if.adb_listen = 1'b0;
        link_if.kbd_in_data = 8'h00;
        link_if.kbd_in_strobe = 1'b0;
        link_if.adb_dout = 8'h00;
        link_if.adb_dout_strobe = 1'b0;

        // Reset
        repeat (4) @(negedge clk);
        check_eq("cpu_reset_held", _cpuReset, 0);
        check_eq("reset_kbdclk", link_if.kbdclk, 1);
        check_eq("reset_busy", via_busy, 0);
        check_eq("reset_kbddata", link_if.kbddata_o, 1);
        _systemReset = 1'b1;
        wait_cpu_reset(200, "cpu_reset_release");
        check_eq("post_reset_busy", via_busy, 0);
        check_eq("post_reset_kbdclk", link_if.kbdclk, 1);

        // Plus transmit of 8'hB4
        en_full = 1'b1;
        machineType = 1'b0;
        exp_half = 1301;
        half_valid = 1'b0;
        byte_q.push_back(8'hB4);
        link_if.cb2_t = 1'b1;
        link_if.cb2_o = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("plus_tx_start", via_busy, 1);
        data = 8'hB4;
        for (int i = 7; i >= 0; i--) begin
            link_if.cb2_o = data[i];
            wait_falls(3000, "plus_tx_fall");
        end
        wait_strobe(1'b0, 3000, "plus_tx_strobe");
        check_eq("plus_wait_rx_kbdclk", link_if.kbdclk, 1);
        check_eq("plus_wait_rx_busy", via_busy, 1);

        // Plus stall: CB2 released, no keyboard byte yet
        link_if.cb2_t = 1'b0;
        f0 = fall_cnt;
        repeat (3000) @(negedge clk);
        check_eq("plus_stall_kbdclk", link_if.kbdclk, 1);
        check_eq("plus_stall_no_fall", fall_cnt - f0, 0);
        check_eq("plus_stall_busy", via_busy, 1);

        // Plus receive of 8'h5A
        half_valid = 1'b0;
        rx_mon = 1'b1;
        data = 8'h5A;
        for (int i = 7; i >= 0; i--) bit_q.push_back(data[i]);
        f0 = fall_cnt;
        link_if.kbd_in_data = 8'h5A;
        link_if.kbd_in_strobe = 1'b1;
        @(negedge clk);
        link_if.kbd_in_strobe = 1'b0;
        wait_idle(25000, "plus_rx_done");
        rx_mon = 1'b0;
        check_eq("plus_rx_falls", fall_cnt - f0, 8);
        check_eq("plus_rx_bits_left", bit_q.size(), 0);
        check_eq("plus_rx_kbdclk", link_if.kbdclk, 1);

        // SE receive of 8'hC3, enable every other clock
        en_full = 1'b0;
        machineType = 1'b1;
        exp_half = 81;
        repeat (4) @(negedge clk);
        half_valid = 1'b0;
        rx_mon = 1'b1;
        data = 8'hC3;
        for (int i = 7; i >= 0; i--) bit_q.push_back(data[i]);
        link_if.adb_dout = 8'hC3;
        link_if.adb_dout_strobe = 1'b1;
        repeat (2) @(negedge clk);
        link_if.adb_dout_strobe = 1'b0;
        check_eq("se_rx_start", via_busy, 1);
        wait_idle(4000, "se_rx_done");
        rx_mon = 1'b0;
        check_eq("se_rx_bits_left", bit_q.size(), 0);

        // SE transmit of 8'h0F
        half_valid = 1'b0;
        byte_q.push_back(8'h0F);
        link_if.cb2_t = 1'b1;
        link_if.cb2_o = 1'b0;
        link_if.adb_listen = 1'b1;
        data = 8'h0F;
        for (int i = 7; i >= 0; i--) begin
            link_if.cb2_o = data[i];
            wait_falls(400, "se_tx_fall");
        end
        wait_strobe(1'b1, 400, "se_tx_strobe");
        check_eq("se_tx_idle", via_busy, 0);
        link_if.adb_listen = 1'b0;
        link_if.cb2_t = 1'b0;
        repeat (6) @(negedge clk);

        // SE transmit aborted by reset after the third bit
        half_valid = 1'b0;
        s0 = adb_strobe_cnt;
        link_if.cb2_t = 1'b1;
        link_if.adb_listen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            link_if.cb2_o = i[0];
            wait_falls(400, "abort_fall");
        end
        wait_clk_high(400, "abort_third_rise");
        half_valid = 1'b0;
        _systemReset = 1'b0;
        link_if.adb_listen = 1'b0;
        #1;
        check_eq("abort_busy", via_busy, 0);
        check_eq("abort_kbdclk", link_if.kbdclk, 1);
        check_eq("abort_cpu_reset", _cpuReset, 0);
        repeat (3) @(negedge clk);
        _systemReset = 1'b1;
        wait_cpu_reset(200, "abort_reset_release");
        f0 = fall_cnt;
        repeat (400) @(negedge clk);
        check_eq("abort_no_strobe", adb_strobe_cnt - s0, 0);
        check_eq("abort_idle", via_busy, 0);
        check_eq("abort_no_clock", fall_cnt - f0, 0);

        check_eq("byte_q_empty", byte_q.size(), 0);
        check_eq("bit_q_empty", bit_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
